// File: rtl/risc_ctrl_pkg.sv
// rtl/risc_ctrl_pkg.sv - shared constants, opcode classes and state encoding for the core control path
package risc_ctrl_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int OPC_W_DEF  = 4;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h8;
    localparam logic [3:0] OP_ST  = 4'h9;
    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_BZ  = 4'hB;
    localparam logic [3:0] OP_BNZ = 4'hC;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        CLS_NOP, CLS_ALU, CLS_LD, CLS_ST, CLS_JMP, CLS_BZ, CLS_BNZ, CLS_HLT
    } op_class_t;

    typedef enum logic [2:0] {
        ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_HALT
    } state_t;

    typedef enum logic [1:0] {
        PC_HOLD, PC_INC, PC_TGT, PC_BR
    } pc_sel_t;

    // Reserved opcodes 0xD/0xE fall through to the NOP class.
    function automatic op_class_t decode_class(input logic [OPC_W_DEF-1:0] op);
        op_class_t cls;
        cls = CLS_NOP;
        if (op >= 4'h1 && op <= 4'h7) cls = CLS_ALU;
        else if (op == OP_LD)         cls = CLS_LD;
        else if (op == OP_ST)         cls = CLS_ST;
        else if (op == OP_JMP)        cls = CLS_JMP;
        else if (op == OP_BZ)         cls = CLS_BZ;
        else if (op == OP_BNZ)        cls = CLS_BNZ;
        else if (op == OP_HLT)        cls = CLS_HLT;
        return cls;
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - next-PC mux: hold, wrapping increment, jump target or conditional branch
module pc_next_sel
    import risc_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W-1:0] pc_q,
    input  logic [ADDR_W-1:0] target,
    input  logic              cond,
    input  pc_sel_t           sel,
    output logic [ADDR_W-1:0] pc_d
);

    localparam logic [ADDR_W-1:0] ONE = 1;

    logic [ADDR_W-1:0] pc_inc;

    // Width-limited add: the top address wraps to zero with no carry out.
    assign pc_inc = pc_q + ONE;

    always_comb begin
        pc_d = pc_q;
        case (sel)
            PC_INC:  pc_d = pc_inc;
            PC_TGT:  pc_d = target;
            PC_BR:   pc_d = cond ? target : pc_inc;
            default: pc_d = pc_q;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - multi-cycle fetch/decode/execute control FSM driving the PC register and strobes
module pc_sequencer
    import risc_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OPC_W  = OPC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_q,
    output logic [ADDR_W-1:0] pc_d,
    output logic              pc_we,
    output logic              imem_req,
    input  logic              imem_ack,
    output logic              ir_we,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [ADDR_W-1:0] target,
    input  logic              zero_flag,
    input  logic              stall,
    output logic              alu_en,
    output logic              rf_we,
    output logic              dmem_rd,
    output logic              dmem_wr,
    input  logic              dmem_ack,
    output logic              halted
);

    state_t            state, state_n;
    op_class_t         cls_q, dec_cls;
    pc_sel_t           pc_sel;
    logic              br_cond;
    logic [ADDR_W-1:0] sel_pc_d;

    assign dec_cls = decode_class(opcode);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
            cls_q <= CLS_NOP;
        end else begin
            state <= state_n;
            if (state == ST_DECODE && !stall)
                cls_q <= dec_cls;
        end
    end

    always_comb begin
        state_n  = state;
        pc_sel   = PC_HOLD;
        br_cond  = 1'b0;
        pc_we    = 1'b0;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        alu_en   = 1'b0;
        rf_we    = 1'b0;
        dmem_rd  = 1'b0;
        dmem_wr  = 1'b0;
        halted   = 1'b0;
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_n = ST_DECODE;
                end
            end
            ST_DECODE: if (!stall) begin
                case (dec_cls)
                    CLS_LD, CLS_ST: state_n = ST_MEM;
                    CLS_JMP: begin
                        pc_we   = 1'b1;
                        pc_sel  = PC_TGT;
                        state_n = ST_FETCH;
                    end
                    CLS_BZ, CLS_BNZ: begin
                        pc_we   = 1'b1;
                        pc_sel  = PC_BR;
                        br_cond = (dec_cls == CLS_BZ) ? zero_flag : !zero_flag;
                        state_n = ST_FETCH;
                    end
                    CLS_HLT: state_n = ST_HALT;
                    default: state_n = ST_EXEC;
                endcase
            end
            ST_EXEC: if (!stall) begin
                alu_en  = (cls_q == CLS_ALU);
                state_n = ST_WB;
            end
            // The memory handshake stays open regardless of stall until acked.
            ST_MEM: begin
                dmem_rd = (cls_q == CLS_LD);
                dmem_wr = (cls_q == CLS_ST);
                if (dmem_ack) begin
                    if (cls_q == CLS_ST) begin
                        pc_we   = 1'b1;
                        pc_sel  = PC_INC;
                        state_n = ST_FETCH;
                    end else begin
                        state_n = ST_WB;
                    end
                end
            end
            ST_WB: if (!stall) begin
                rf_we   = (cls_q == CLS_ALU) || (cls_q == CLS_LD);
                pc_we   = 1'b1;
                pc_sel  = PC_INC;
                state_n = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_n = ST_FETCH;
        endcase
        if (rst) begin
            pc_sel   = PC_HOLD;
            pc_we    = 1'b0;
            imem_req = 1'b0;
            ir_we    = 1'b0;
            alu_en   = 1'b0;
            rf_we    = 1'b0;
            dmem_rd  = 1'b0;
            dmem_wr  = 1'b0;
            halted   = 1'b0;
        end
    end

    pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
        .pc_q   (pc_q),
        .target (target),
        .cond   (br_cond),
        .sel    (pc_sel),
        .pc_d   (sel_pc_d)
    );

    assign pc_d = rst ? '0 : sel_pc_d;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized instruction-level bench for pc_sequencer
module tb_pc_sequencer;

    localparam logic [6:0] S_REQ = 7'b1000000;
    localparam logic [6:0] S_IR  = 7'b0100000;
    localparam logic [6:0] S_ALU = 7'b0010000;
    localparam logic [6:0] S_RF  = 7'b0001000;
    localparam logic [6:0] S_RD  = 7'b0000100;
    localparam logic [6:0] S_WR  = 7'b0000010;
    localparam logic [6:0] S_HLT = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst, imem_ack, zero_flag, stall, dmem_ack;
    logic [6:0] pc_q, target, pc_d;
    logic [3:0] opcode;
    logic       pc_we, imem_req, ir_we, alu_en, rf_we, dmem_rd, dmem_wr, halted;
    logic [14:0] outv;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign outv = {pc_d, pc_we, imem_req, ir_we, alu_en, rf_we, dmem_rd, dmem_wr, halted};

    pc_sequencer dut (
        .clk(clk), .rst(rst), .pc_q(pc_q), .pc_d(pc_d), .pc_we(pc_we),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
        .opcode(opcode), .target(target), .zero_flag(zero_flag), .stall(stall),
        .alu_en(alu_en), .rf_we(rf_we), .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
        .dmem_ack(dmem_ack), .halted(halted)
    );

    task automatic check_vec(input string tag, input logic [14:0] got, input logic [14:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got pc_d=%h flags=%b, expected pc_d=%h flags=%b",
                     tag, got[14:8], got[7:0], exp[14:8], exp[7:0]);
        end
    endtask

    // Expected output word; pc_d must mirror pc_q whenever no PC write happens.
    function automatic logic [14:0] ev(input logic we, input logic [6:0] nd, input logic [6:0] s);
        return {(we ? nd : pc_q), we, s};
    endfunction

    task automatic cyc(input string tag, input logic [14:0] exp);
        #1;
        check_vec(tag, outv, exp);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ack = 1'($urandom); dmem_ack = 1'($urandom); stall = 1'($urandom);
        opcode = 4'($urandom); target = 7'($urandom); zero_flag = 1'($urandom);
        cyc("reset", 15'd0);
        rst = 1'b0;
        pc_q = 7'd0;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [6:0] tgt, input logic zf,
                             input int fw, input int sd, input int se, input int mw, input int sw);
        logic [6:0] npc;
        logic is_alu, is_ld;
        is_alu = (op >= 4'h1 && op <= 4'h7);
        is_ld  = (op == 4'h8);
        for (int i = 0; i < fw; i++) begin
            imem_ack = 1'b0; stall = 1'($urandom); dmem_ack = 1'($urandom); opcode = 4'($urandom);
            cyc("fetch_wait", ev(1'b0, 7'd0, S_REQ));
        end
        imem_ack = 1'b1; stall = 1'($urandom); dmem_ack = 1'($urandom);
        cyc("fetch_ack", ev(1'b0, 7'd0, S_REQ | S_IR));

        opcode = op; target = tgt; zero_flag = zf;
        imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
        for (int i = 0; i < sd; i++) begin
            stall = 1'b1;
            cyc("decode_stall", ev(1'b0, 7'd0, 7'd0));
        end
        stall = 1'b0;
        if (op == 4'hA || op == 4'hB || op == 4'hC) begin
            if (op == 4'hA)      npc = tgt;
            else if (op == 4'hB) npc = zf ? tgt : pc_q + 7'd1;
            else                 npc = !zf ? tgt : pc_q + 7'd1;
            cyc("branch", ev(1'b1, npc, 7'd0));
            pc_q = npc;
            return;
        end
        if (op == 4'hF) begin
            cyc("hlt_decode", ev(1'b0, 7'd0, 7'd0));
            for (int i = 0; i < 5; i++) begin
                imem_ack = 1'($urandom); dmem_ack = 1'($urandom); stall = 1'($urandom);
                opcode = 4'($urandom); zero_flag = 1'($urandom);
                cyc("halted", ev(1'b0, 7'd0, S_HLT));
            end
            do_reset();
            return;
        end
        cyc("decode", ev(1'b0, 7'd0, 7'd0));
        // Only the class latched at decode may matter from here on.
        opcode = 4'($urandom); zero_flag = 1'($urandom); target = 7'($urandom);

        if (op == 4'h8 || op == 4'h9) begin
            for (int i = 0; i < mw; i++) begin
                dmem_ack = 1'b0; stall = 1'($urandom); imem_ack = 1'($urandom);
                cyc("mem_wait", ev(1'b0, 7'd0, is_ld ? S_RD : S_WR));
            end
            dmem_ack = 1'b1; stall = 1'($urandom);
            if (!is_ld) begin
                npc = pc_q + 7'd1;
                cyc("st_ack", ev(1'b1, npc, S_WR));
                pc_q = npc;
                return;
            end
            cyc("ld_ack", ev(1'b0, 7'd0, S_RD));
        end else begin
            for (int i = 0; i < se; i++) begin
                stall = 1'b1; dmem_ack = 1'($urandom);
                cyc("exec_stall", ev(1'b0, 7'd0, 7'd0));
            end
            stall = 1'b0; dmem_ack = 1'($urandom);
            cyc("exec", ev(1'b0, 7'd0, is_alu ? S_ALU : 7'd0));
        end
        for (int i = 0; i < sw; i++) begin
            stall = 1'b1; dmem_ack = 1'($urandom);
            cyc("wb_stall", ev(1'b0, 7'd0, 7'd0));
        end
        stall = 1'b0;
        npc = pc_q + 7'd1;
        cyc("wb", ev(1'b1, npc, (is_alu || is_ld) ? S_RF : 7'd0));
        pc_q = npc;
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; stall = 1'b0;
        zero_flag = 1'b0; opcode = 4'h0; target = 7'h0; pc_q = 7'h33;
        @(negedge clk);
        do_reset();

        run_instr(4'h3, 7'h15, 1'b0, 0, 0, 0, 0, 0);
        run_instr(4'hB, 7'h40, 1'b1, 0, 0, 0, 0, 0);
        pc_q = 7'h10;
        run_instr(4'hB, 7'h40, 1'b0, 0, 0, 0, 0, 0);
        pc_q = 7'h7F;
        run_instr(4'h0, 7'h22, 1'b0, 0, 0, 0, 0, 0);
        run_instr(4'h8, 7'h05, 1'b0, 1, 1, 0, 3, 0);
        run_instr(4'h5, 7'h05, 1'b0, 0, 0, 1, 0, 2);
        run_instr(4'hC, 7'h2A, 1'b0, 2, 0, 0, 0, 0);
        run_instr(4'hA, 7'h7F, 1'b1, 0, 1, 0, 0, 0);
        run_instr(4'h9, 7'h01, 1'b0, 0, 0, 0, 2, 0);
        run_instr(4'hD, 7'h01, 1'b1, 0, 0, 1, 0, 1);
        run_instr(4'hF, 7'h00, 1'b0, 0, 0, 0, 0, 0);

        // Abort a load mid-handshake; the next instruction must start from fetch.
        pc_q = 7'h20;
        imem_ack = 1'b1; stall = 1'b0; dmem_ack = 1'b0;
        cyc("abort_fetch", ev(1'b0, 7'd0, S_REQ | S_IR));
        opcode = 4'h8;
        cyc("abort_decode", ev(1'b0, 7'd0, 7'd0));
        cyc("abort_mem", ev(1'b0, 7'd0, S_RD));
        do_reset();

        for (int n = 0; n < 200; n++) begin
            run_instr(4'($urandom), 7'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
